xcver_link_sync: RTL
====================

Name: xcver_link_sync

Overview:
- Multi-lane link bring-up and code-group synchronisation controller between the transceiver hard IP and the PCS/SGMII logic.
- Replaces the ad-hoc signal-detect derivation with two functions:
  - a per-lane IEEE 802.3 Clause-36-style synchronisation FSM, with parametrised comma count and loss hysteresis;
  - a reset/bring-up sequencer that drives the transceiver digital reset, retries on sync timeout and qualifies link-up.
- Word alignment is done by the transceiver. Even/odd is not tracked.

Parameters:
- pLanes, 1, number of lanes (1..8).
- pCommaCount, 3, comma+data pairs needed to acquire sync (2..7).
- pGoodCgs, 4, consecutive good code groups needed to step back one error level.
- pBadLevels, 4, error levels tolerated while synced; a bad code group at the last level causes loss.
- pRstHold, 64, cycles synchronised PLL lock must be high before digital reset releases.
- pSyncTimeout, 1048576, cycles allowed in ALIGN before a retry.
- pLinkUpDelay, 16, cycles all lanes must stay synced before link-up.

Ports:
- i_Clk  in  1  code-group clock (transceiver tx_clkout domain).
- i_Rst  in  1  asynchronous, active-high reset.
- i_PllLocked  in  1  transceiver PLL lock; asynchronous, 2-flop synchronised internally.
- iv_RxCodeGroup  in  8*pLanes  decoded code groups; lane n occupies bits [8n+7:8n].
- iv_RxCodeCtrl  in  pLanes  K-character flag per lane.
- iv_RxCodeInvalid  in  pLanes  8b/10b code violation per lane.
- iv_RxDispErr  in  pLanes  disparity error per lane.
- o_XcverDigitalRst  out  1  to transceiver rx/tx digital reset.
- ov_LaneSync  out  pLanes  per-lane sync status.
- o_LinkUp  out  1  all lanes synced and qualified.
- o_Retry  out  1  one-cycle pulse on sync timeout.
- ov_LossCnt  out  16*pLanes  per-lane saturating loss-of-sync count.

Behaviour:
- Reset values:
  - o_XcverDigitalRst = 1.
  - ov_LaneSync, o_LinkUp, o_Retry, ov_LossCnt = 0.
  - Sequencer in HOLD; all lanes in LOSS.
- Code-group classification:
  - comma: ctrl = 1 and code in {8'hBC, 8'h3C, 8'hFC}.
  - cgbad: invalid or disperr.
  - cgood: not cgbad.
- Lane FSM, evaluated every cycle; forced to LOSS while o_XcverDigitalRst = 1:
  - LOSS: comma & cgood -> CD with k = 1. Otherwise stay.
  - CD(k): cgood & ~ctrl -> SYNC (L = 0, g = 0) if k == pCommaCount, else ACQ. Any other input -> LOSS.
  - ACQ: cgbad -> LOSS. comma & cgood -> CD(k+1). Otherwise stay.
  - SYNC(L, g):
    - cgbad: if L == pBadLevels-1 -> LOSS; else L+1, g = 0.
    - cgood with L > 0: g+1; when g+1 == pGoodCgs -> L-1, g = 0.
    - cgood with L == 0: no change.
- ov_LaneSync[n] is registered (state == SYNC): 1-cycle latency after the qualifying data code group.
- ov_LossCnt[n]:
  - increments on a SYNC -> LOSS transition caused by cgbad;
  - saturates at 16'hFFFF;
  - cleared only by i_Rst;
  - not incremented by a forced LOSS from digital reset.
- Sequencer states, with one shared counter cleared on every state change:
  - HOLD: o_XcverDigitalRst = 1. Counter increments while lock_s = 1 and clears when lock_s = 0. Counter == pRstHold-1 -> ALIGN.
  - ALIGN: o_XcverDigitalRst = 0. Counter increments each cycle.
    - All ov_LaneSync = 1 -> SETTLE.
    - Else counter == pSyncTimeout-1 -> HOLD, with o_Retry = 1 for one cycle.
  - SETTLE: any lane not synced -> ALIGN. Counter == pLinkUpDelay-1 -> UP.
  - UP: o_LinkUp = 1 (registered). Any lane drops -> ALIGN and o_LinkUp = 0 the next cycle.
- Priority: lock_s = 0 in ALIGN, SETTLE or UP -> HOLD, overriding every other transition, including a timeout in the same cycle.
- If all lanes sync on the timeout cycle, SETTLE wins over the retry.
- Counter width is $clog2 of the largest of pRstHold, pSyncTimeout and pLinkUpDelay; the counter never wraps.
- An asynchronous i_Rst mid-operation returns everything to reset values immediately.

Decomposition:
- Package xcver_pkg holds:
  - comma constants (K28_5 = 8'hBC, K28_1 = 8'h3C, K28_7 = 8'hFC);
  - the lane-state enum (LOSS, CD, ACQ, SYNC);
  - the sequencer-state enum (HOLD, ALIGN, SETTLE, UP).
- Sub-module xcver_lane_sync: one lane's FSM plus its loss counter, instantiated pLanes times in a generate loop.
- Sequencer, lock synchroniser and lane aggregation stay in the top.

Test Plan:
- Bring-up: i_Rst pulse, i_PllLocked = 1, pRstHold = 64 -> o_XcverDigitalRst falls exactly 66 cycles after reset release (2 synchroniser + 64 hold).
- Acquisition (pLanes = 2):
  - lane0 fed K28.5, D16.2 three times -> ov_LaneSync[0] = 1 on the cycle after the 3rd D16.2;
  - only two pairs, then a bad code group -> stays 0;
  - K28.5 followed by K28.5 -> back to LOSS.
- Hysteresis:
  - in sync, 3 invalid code groups, each followed by 2 good -> stays synced;
  - a 4th invalid -> ov_LaneSync[0] = 0 next cycle and ov_LossCnt[0] = 1.
- Recovery: 1 invalid, then 4 good -> level 0; then 3 invalid interleaved with good -> still synced.
- Timeout: pSyncTimeout = 1000, lane1 sends only D-codes -> o_Retry pulses 1000 cycles after ALIGN entry, o_XcverDigitalRst = 1 the same cycle, ov_LossCnt unchanged.
- Link-up and lock loss:
  - both lanes synced, pLinkUpDelay = 16 -> o_LinkUp = 1 after 16 cycles in SETTLE plus 1;
  - i_PllLocked then drops -> o_LinkUp = 0 and o_XcverDigitalRst = 1 within 3 cycles.

Source files
------------

// File: rtl/xcver_pkg.sv
// Shared constants and state types for the transceiver link bring-up and
// code-group synchronisation logic.
package xcver_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_7 = 8'hFC;

    typedef enum logic [1:0] {LnLoss, LnCd, LnAcq, LnSync} laneStateT;

    typedef enum logic [1:0] {SqHold, SqAlign, SqSettle, SqUp} seqStateT;

    function automatic logic isComma(input logic [7:0] code, input logic ctrl);
        return ctrl && (code inside {K28_5, K28_1, K28_7});
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/xcver_lane_sync.sv
// Single-lane code-group synchronisation FSM with error-level hysteresis and
// a saturating loss-of-sync counter.
module xcver_lane_sync
    import xcver_pkg::*;
#(
    parameter int unsigned pCommaCount = 3,
    parameter int unsigned pGoodCgs    = 4,
    parameter int unsigned pBadLevels  = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Force,
    input  logic [7:0]  i_Code,
    input  logic        i_Ctrl,
    input  logic        i_Invalid,
    input  logic        i_DispErr,
    output logic        o_Sync,
    output logic [15:0] o_LossCnt
);

    localparam int unsigned KW   = $clog2(pCommaCount + 1);
    localparam int unsigned LvlW = (pBadLevels > 1) ? $clog2(pBadLevels) : 1;
    localparam int unsigned GW   = $clog2(pGoodCgs + 1);

    laneStateT       stateQ, stateD;
    logic [KW-1:0]   kQ, kD;
    logic [LvlW-1:0] lvlQ, lvlD;
    logic [GW-1:0]   gQ, gD;
    logic [15:0]     lossQ;
    logic            lossEvt;
    logic            bad, comma;

    assign bad   = i_Invalid | i_DispErr;
    assign comma = isComma(i_Code, i_Ctrl);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            stateQ <= LnLoss;
            kQ     <= '0;
            lvlQ   <= '0;
            gQ     <= '0;
            lossQ  <= '0;
        end else begin
            stateQ <= stateD;
            kQ     <= kD;
            lvlQ   <= lvlD;
            gQ     <= gD;
            if (lossEvt && lossQ != 16'hFFFF) begin
                lossQ <= lossQ + 16'd1;
            end
        end
    end

    always_comb begin
        stateD  = stateQ;
        kD      = kQ;
        lvlD    = lvlQ;
        gD      = gQ;
        lossEvt = 1'b0;
        if (i_Force) begin
            stateD = LnLoss;
        end else begin
            case (stateQ)
                LnLoss: begin
                    if (comma && !bad) begin
                        stateD = LnCd;
                        kD     = KW'(1);
                    end
                end
                LnCd: begin
                    if (!bad && !i_Ctrl) begin
                        stateD = (kQ == KW'(pCommaCount)) ? LnSync : LnAcq;
                        lvlD   = '0;
                        gD     = '0;
                    end else begin
                        stateD = LnLoss;
                    end
                end
                LnAcq: begin
                    if (bad) begin
                        stateD = LnLoss;
                    end else if (comma) begin
                        stateD = LnCd;
                        kD     = kQ + 1'b1;
                    end
                end
                LnSync: begin
                    if (bad) begin
                        if (lvlQ == LvlW'(pBadLevels - 1)) begin
                            stateD  = LnLoss;
                            lossEvt = 1'b1;
                        end else begin
                            lvlD = lvlQ + 1'b1;
                            gD   = '0;
                        end
                    end else if (lvlQ != '0) begin
                        if (gQ + 1'b1 == GW'(pGoodCgs)) begin
                            lvlD = lvlQ - 1'b1;
                            gD   = '0;
                        end else begin
                            gD = gQ + 1'b1;
                        end
                    end
                end
                default: stateD = LnLoss;
            endcase
        end
    end

    always_comb begin
        o_Sync    = (stateQ == LnSync);
        o_LossCnt = lossQ;
    end

endmodule

// File: rtl/xcver_link_sync.sv
// Multi-lane link bring-up: PLL-lock qualified digital reset release, sync
// timeout retry and link-up qualification over per-lane sync FSMs.
module xcver_link_sync
    import xcver_pkg::*;
#(
    parameter int unsigned pLanes       = 1,
    parameter int unsigned pCommaCount  = 3,
    parameter int unsigned pGoodCgs     = 4,
    parameter int unsigned pBadLevels   = 4,
    parameter int unsigned pRstHold     = 64,
    parameter int unsigned pSyncTimeout = 1048576,
    parameter int unsigned pLinkUpDelay = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_PllLocked,
    input  logic [8*pLanes-1:0]   iv_RxCodeGroup,
    input  logic [pLanes-1:0]     iv_RxCodeCtrl,
    input  logic [pLanes-1:0]     iv_RxCodeInvalid,
    input  logic [pLanes-1:0]     iv_RxDispErr,
    output logic                  o_XcverDigitalRst,
    output logic [pLanes-1:0]     ov_LaneSync,
    output logic                  o_LinkUp,
    output logic                  o_Retry,
    output logic [16*pLanes-1:0]  ov_LossCnt
);

    localparam int unsigned CntMax = max3(pRstHold, pSyncTimeout, pLinkUpDelay);
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    seqStateT          seqQ, seqD;
    logic [CntW-1:0]   cntQ, cntD, cntInc;
    logic              retryQ, retryD;
    logic              lockMetaQ, lockSQ;
    logic              digRst;
    logic              allSync;
    logic [pLanes-1:0] laneSync;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            lockMetaQ <= 1'b0;
            lockSQ    <= 1'b0;
        end else begin
            lockMetaQ <= i_PllLocked;
            lockSQ    <= lockMetaQ;
        end
    end

    for (genvar gi = 0; gi < pLanes; gi++) begin : gLane
        xcver_lane_sync #(
            .pCommaCount(pCommaCount),
            .pGoodCgs   (pGoodCgs),
            .pBadLevels (pBadLevels)
        ) uLane (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Force  (digRst),
            .i_Code   (iv_RxCodeGroup[8*gi +: 8]),
            .i_Ctrl   (iv_RxCodeCtrl[gi]),
            .i_Invalid(iv_RxCodeInvalid[gi]),
            .i_DispErr(iv_RxDispErr[gi]),
            .o_Sync   (laneSync[gi]),
            .o_LossCnt(ov_LossCnt[16*gi +: 16])
        );
    end

    assign allSync = &laneSync;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            seqQ   <= SqHold;
            cntQ   <= '0;
            retryQ <= 1'b0;
        end else begin
            seqQ   <= seqD;
            cntQ   <= cntD;
            retryQ <= retryD;
        end
    end

    // Lock loss outranks everything; all-synced outranks the timeout retry.
    always_comb begin
        seqD   = seqQ;
        retryD = 1'b0;
        case (seqQ)
            SqHold: begin
                if (lockSQ && cntQ == CntW'(pRstHold - 1)) seqD = SqAlign;
            end
            SqAlign: begin
                if (!lockSQ) begin
                    seqD = SqHold;
                end else if (allSync) begin
                    seqD = SqSettle;
                end else if (cntQ == CntW'(pSyncTimeout - 1)) begin
                    seqD   = SqHold;
                    retryD = 1'b1;
                end
            end
            SqSettle: begin
                if (!lockSQ) begin
                    seqD = SqHold;
                end else if (!allSync) begin
                    seqD = SqAlign;
                end else if (cntQ == CntW'(pLinkUpDelay - 1)) begin
                    seqD = SqUp;
                end
            end
            SqUp: begin
                if (!lockSQ) begin
                    seqD = SqHold;
                end else if (!allSync) begin
                    seqD = SqAlign;
                end
            end
            default: seqD = SqHold;
        endcase

        cntInc = (cntQ == '1) ? cntQ : cntQ + 1'b1;
        if (seqD != seqQ) begin
            cntD = '0;
        end else begin
            case (seqQ)
                SqHold:            cntD = lockSQ ? cntInc : '0;
                SqAlign, SqSettle: cntD = cntInc;
                default:           cntD = cntQ;
            endcase
        end
    end

    always_comb begin
        digRst            = (seqQ == SqHold);
        o_XcverDigitalRst = digRst;
        o_LinkUp          = (seqQ == SqUp);
        o_Retry           = retryQ;
        ov_LaneSync       = laneSync;
    end

endmodule
